// File: rtl/upsample_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upsample_pkg
// Purpose  : Shared definitions for the 2x nearest-neighbour upsampler:
//            row-phase state encoding and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package upsample_pkg;

  // ROW_EVEN: first output row of a pooled row, fed from the input stream.
  // ROW_ODD : second output row, replayed from the line buffer.
  typedef enum logic [0:0] {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } state_e;

  // ceil(log2(value)), never less than 1, so a counter for a single-entry
  // range still has a legal one-bit width.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        bits = i + 1;
      end
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/upsample_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : upsample_line_buffer
// Purpose  : One pooled row of pixel storage. Synchronous write, combinational
//            read. Contents are not reset.
// Ports    : clk       - clock
//            wr_en     - write strobe
//            wr_addr   - write column
//            wr_data   - pixel to store
//            rd_addr   - read column
//            rd_data   - stored pixel (zero for addresses past the row end)
// Revision : 1.0 - initial release
// ============================================================================
module upsample_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 14,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_en && (int'(wr_addr) == i)) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // The caller may present col+1 on the final column; that read is unused,
  // so out-of-range addresses simply return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < WIDTH) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/upsample_unit.sv
`default_nettype none
// ============================================================================
// Module   : upsample_unit
// Purpose  : Streaming 2x nearest-neighbour upsampler. Each raster-order input
//            pixel becomes a 2x2 output block; the output is also raster order.
//            The even output row is produced from the live stream, and the odd
//            row is replayed from a one-row line buffer.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            in_data/in_valid/in_ready     - pooled pixel stream
//            out_data/out_valid/out_ready  - upsampled pixel stream
//            out_last        - last pixel of each plane
//            out_frame_last  - last pixel of the last plane
// Revision : 1.0 - initial release
// ============================================================================
module upsample_unit
  import upsample_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_H     = 14,
  parameter int POOL_W     = 14,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_frame_last
);

  localparam int COL_W   = clog2_min1(POOL_W);
  localparam int ROW_W   = clog2_min1(POOL_H);
  localparam int PLANE_W = clog2_min1(DEPTH);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(POOL_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(POOL_H - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [PLANE_W-1:0]    plane_q, plane_d;
  logic                  dup_q, dup_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_frame_last_q, out_frame_last_d;

  logic                  end_of_row;
  logic                  out_fire;
  logic                  in_fire;
  logic [COL_W-1:0]      col_inc;
  logic [COL_W-1:0]      lb_wr_addr;
  logic [COL_W-1:0]      lb_rd_addr;
  logic [DATA_WIDTH-1:0] lb_rd_data;

  assign end_of_row = (col_q == COL_LAST);
  assign out_fire   = out_valid_q && out_ready;
  assign col_inc    = col_q + 1'b1;

  // Input is accepted only in the even phase, either into an empty output
  // register or as a same-cycle replacement for a finished second copy.
  // Never accepted on the last column so the odd-row preload wins.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && (state_q == ROW_EVEN)) begin
      in_ready = !out_valid_q || (out_ready && dup_q && !end_of_row);
    end
  end

  assign in_fire = in_valid && in_ready;

  // With an occupied output register the accepted pixel belongs to the next
  // column; with an empty one, col already points at it.
  assign lb_wr_addr = out_valid_q ? col_inc : col_q;
  // Odd-row replay fetches the next column; entering the odd row needs column 0.
  assign lb_rd_addr = (state_q == ROW_ODD) ? col_inc : '0;

  upsample_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIDTH      (POOL_W),
    .ADDR_W     (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_addr (lb_wr_addr),
    .wr_data (in_data),
    .rd_addr (lb_rd_addr),
    .rd_data (lb_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    plane_d     = plane_q;
    dup_d       = dup_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      ROW_EVEN: begin
        if (out_fire) begin
          if (!dup_q) begin
            dup_d = 1'b1;
          end else if (!end_of_row) begin
            col_d       = col_inc;
            dup_d       = 1'b0;
            out_valid_d = 1'b0;
          end else begin
            col_d      = '0;
            dup_d      = 1'b0;
            out_data_d = lb_rd_data;
            state_d    = ROW_ODD;
          end
        end
        // A same-cycle accept overrides the bubble set above.
        if (in_fire) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          dup_d       = 1'b0;
        end
      end

      ROW_ODD: begin
        if (out_fire) begin
          if (!dup_q) begin
            dup_d = 1'b1;
          end else if (!end_of_row) begin
            col_d      = col_inc;
            out_data_d = lb_rd_data;
            dup_d      = 1'b0;
          end else begin
            out_valid_d = 1'b0;
            col_d       = '0;
            dup_d       = 1'b0;
            state_d     = ROW_EVEN;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              plane_d = (plane_q == PLANE_LAST) ? '0 : plane_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ROW_EVEN;
      end
    endcase
  end

  // Flags are a function of the next position, so they register alongside
  // the beat they qualify and stay stable through stalls.
  always_comb begin
    out_last_d       = (state_d == ROW_ODD) && (row_d == ROW_LAST) &&
                       (col_d == COL_LAST) && dup_d;
    out_frame_last_d = out_last_d && (plane_d == PLANE_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ROW_EVEN;
      col_q            <= '0;
      row_q            <= '0;
      plane_q          <= '0;
      dup_q            <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_last_q       <= 1'b0;
      out_frame_last_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      col_q            <= col_d;
      row_q            <= row_d;
      plane_q          <= plane_d;
      dup_q            <= dup_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_last_q       <= out_last_d;
      out_frame_last_q <= out_frame_last_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign out_frame_last = out_frame_last_q;

endmodule
`default_nettype wire

// File: tb/tb_upsample_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_upsample_unit
// Purpose  : Self-checking bench for upsample_unit. Three instances cover a
//            2x2x1, a 2x2x2 and a 1x3x1 map; one is selected at a time and its
//            output stream is compared against a queue of expected beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upsample_unit;

  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          fl;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          out_ready;
  logic [1:0]    sel;

  logic [2:0]    in_ready_v;
  logic [2:0]    out_valid_v;
  logic [2:0]    out_last_v;
  logic [2:0]    out_flast_v;
  logic [DW-1:0] out_data_v [3];

  logic          obs_in_ready, obs_valid, obs_last, obs_flast;
  logic [DW-1:0] obs_data;

  beat_t         exp_q[$];
  logic [DW-1:0] stim [16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats = 0;
  int first_valid = -1;
  int last_beat   = 0;
  int rmode = 0;
  int rcnt  = 0;
  bit abort = 1'b0;
  bit drv_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  upsample_unit #(.DATA_WIDTH(DW), .POOL_H(2), .POOL_W(2), .DEPTH(1)) u_a (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd0)), .in_ready(in_ready_v[0]),
    .out_data(out_data_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready || (sel != 2'd0)),
    .out_last(out_last_v[0]), .out_frame_last(out_flast_v[0])
  );

  upsample_unit #(.DATA_WIDTH(DW), .POOL_H(2), .POOL_W(2), .DEPTH(2)) u_b (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd1)), .in_ready(in_ready_v[1]),
    .out_data(out_data_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready || (sel != 2'd1)),
    .out_last(out_last_v[1]), .out_frame_last(out_flast_v[1])
  );

  upsample_unit #(.DATA_WIDTH(DW), .POOL_H(1), .POOL_W(3), .DEPTH(1)) u_c (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd2)), .in_ready(in_ready_v[2]),
    .out_data(out_data_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready || (sel != 2'd2)),
    .out_last(out_last_v[2]), .out_frame_last(out_flast_v[2])
  );

  assign obs_in_ready = in_ready_v[sel];
  assign obs_valid    = out_valid_v[sel];
  assign obs_last     = out_last_v[sel];
  assign obs_flast    = out_flast_v[sel];
  assign obs_data     = out_data_v[sel];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected 2x2 expansion built directly from the stimulus table.
  task automatic build_expected(input int h, input int w, input int d);
    beat_t b;
    for (int p = 0; p < d; p++)
      for (int r = 0; r < h; r++)
        for (int rep = 0; rep < 2; rep++)
          for (int c = 0; c < w; c++)
            for (int k = 0; k < 2; k++) begin
              b.d  = stim[p*h*w + r*w + c];
              b.l  = (r == h-1) && (rep == 1) && (c == w-1) && (k == 1);
              b.fl = b.l && (p == d-1);
              exp_q.push_back(b);
            end
  endtask

  // Output ready pattern: mode 0 always ready, mode 1 repeats 1,0,0.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode == 1) begin
        out_ready = (rcnt % 3 == 0);
        rcnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor: sampled on the falling edge, where inputs are settled.
  initial begin
    beat_t e;
    bit prev_stall;
    logic [31:0] prev_val;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (obs_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) check_val("stall_hold", {14'd0, obs_last, obs_flast, obs_data}, prev_val);
        if (obs_valid && out_ready) begin
          check_val("queue_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("data", obs_data, e.d);
            check_val("out_last", obs_last, e.l);
            check_val("out_frame_last", obs_flast, e.fl);
          end
          beats++;
          last_beat = cyc;
        end
        if (obs_valid && !out_ready) check_val("stall_in_ready", obs_in_ready, 0);
        prev_stall = obs_valid && !out_ready;
        prev_val   = {14'd0, obs_last, obs_flast, obs_data};
      end
    end
  end

  task automatic drive_seq(input int n, input int gap);
    for (int i = 0; i < n && !abort; i++) begin
      int waitc;
      bit acc;
      waitc = 0;
      acc = 1'b0;
      in_data  = stim[i];
      in_valid = 1'b1;
      while (!acc && !abort) begin
        @(negedge clk);
        acc = obs_in_ready;
        @(posedge clk); #1;
        waitc++;
        if (!acc && waitc > 300) begin
          check_val("in_timeout", waitc, 0);
          abort = 1'b1;
        end
      end
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("drain", exp_q.size(), 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input logic [1:0] k, input int h, input int w, input int d,
                           input int gap, input int rm);
    sel   = k;
    rmode = rm;
    rcnt  = 0;
    exp_q.delete();
    build_expected(h, w, d);
    first_valid = -1;
    beats = 0;
    drive_seq(h*w*d, gap);
    wait_drain();
    check_val("beat_count", beats, 4*h*w*d);
  endtask

  initial begin
    int t;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", {29'd0, in_ready_v}, 0);
    check_val("rst_out_valid", {29'd0, out_valid_v}, 0);
    check_val("rst_out_last", {29'd0, out_last_v | out_flast_v}, 0);
    check_val("rst_out_data", out_data_v[0], 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("idle_in_ready", {29'd0, in_ready_v}, 7);

    // Basic 2x2 expansion, full throughput.
    for (int i = 0; i < 4; i++) stim[i] = DW'(i + 1);
    run_frame(2'd0, 2, 2, 1, 0, 0);
    check_val("span_basic", last_beat - first_valid + 1, 17);

    // Backpressure with ready pattern 1,0,0.
    run_frame(2'd0, 2, 2, 1, 0, 1);

    // Input starvation, three idle cycles between pixels.
    run_frame(2'd0, 2, 2, 1, 3, 0);

    // Two planes.
    for (int i = 0; i < 8; i++) stim[i] = DW'(i + 1);
    run_frame(2'd1, 2, 2, 2, 0, 0);
    check_val("span_two_planes", last_beat - first_valid + 1, 35);

    // Non-square single row.
    stim[0] = 16'd10; stim[1] = 16'd20; stim[2] = 16'd30;
    run_frame(2'd2, 1, 3, 1, 0, 0);
    check_val("span_nonsquare", last_beat - first_valid + 1, 12);

    // Reset after six output beats, then a fresh frame.
    for (int i = 0; i < 4; i++) stim[i] = DW'(i + 1);
    sel = 2'd0; rmode = 0; exp_q.delete(); build_expected(2, 2, 1);
    beats = 0; drv_done = 1'b0; abort = 1'b0;
    fork
      begin
        drive_seq(4, 0);
        drv_done = 1'b1;
      end
    join_none
    t = 0;
    while (beats < 6 && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    check_val("pre_reset_beats", 32'(beats >= 6), 1);
    abort = 1'b1;
    reset = 1'b1;
    #1;
    check_val("mid_rst_in_ready", obs_in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("post_rst_valid", obs_valid, 0);
    check_val("post_rst_data", obs_data, 0);
    check_val("post_rst_last", obs_last, 0);
    exp_q.delete();
    t = 0;
    while (!drv_done && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("driver_stopped", drv_done, 1);
    abort = 1'b0;
    @(posedge clk); #1;
    stim[0] = 16'd9; stim[1] = 16'd8; stim[2] = 16'd7; stim[3] = 16'd6;
    run_frame(2'd0, 2, 2, 1, 0, 0);
    check_val("span_after_reset", last_beat - first_valid + 1, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
